// File: rtl/conv_window_feeder.sv
// conv_window_feeder: steps a 3x3 window over an IMG_W x IMG_H image in row-major
// order. For each output position it reads nine pixels, starts the external MAC,
// waits for its result and writes that result to the result memory.
// Optional feature: define CONV_FEEDER_RELU_EN to write negative (signed) MAC
// results as zero. When the macro is undefined, results are written unmodified.
// The ReLU is folded into the result capture, so latency is the same either way.
//
// state | meaning
// IDLE  | waiting for go
// FETCH | issuing the nine tap reads (k = 0..8)
// LAST  | capturing the data for tap 8
// START | one-cycle mac_start pulse, taps stable
// WAIT  | waiting for mac_done, capturing mac_P
// WRITE | one-cycle res_we, then next position or finish
module conv_window_feeder #(
    parameter  int NBITS = 16,
    parameter  int IMG_W = 8,
    parameter  int IMG_H = 8,
    localparam int AW    = $clog2(IMG_W * IMG_H),
    localparam int RW    = $clog2((IMG_W - 2) * (IMG_H - 2))
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    output logic               busy,
    output logic               finished,
    output logic               img_rd,
    output logic [AW-1:0]      img_addr,
    input  logic [NBITS-1:0]   img_data,
    output logic [9*NBITS-1:0] mac_inputs9,
    output logic               mac_start,
    input  logic               mac_done,
    input  logic [NBITS-1:0]   mac_P,
    output logic               res_we,
    output logic [RW-1:0]      res_addr,
    output logic [NBITS-1:0]   res_data
);

    typedef enum logic [2:0] {IDLE, FETCH, LAST, START, WAIT, WRITE} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              k_q, k_d;
    logic [AW-1:0]           row_q, row_d, col_q, col_d;
    logic [8:0][NBITS-1:0]   taps_q, taps_d;
    logic                    img_rd_q, img_rd_d;
    logic [AW-1:0]           img_addr_q, img_addr_d;
    logic                    mac_start_q, mac_start_d;
    logic                    res_we_q, res_we_d;
    logic [RW-1:0]           res_addr_q, res_addr_d;
    logic [NBITS-1:0]        res_data_q, res_data_d;
    logic                    finished_q, finished_d;

    // Pixel address of tap k for the window whose top-left corner is (r, c).
    function automatic logic [AW-1:0] fetch_addr(input logic [AW-1:0] r,
                                                 input logic [AW-1:0] c,
                                                 input logic [3:0] k);
        int a;
        a = (int'(r) + int'(k) / 3) * IMG_W + int'(c) + int'(k) % 3;
        return a[AW-1:0];
    endfunction

    function automatic logic [RW-1:0] res_index(input logic [AW-1:0] r,
                                                input logic [AW-1:0] c);
        int a;
        a = int'(r) * (IMG_W - 2) + int'(c);
        return a[RW-1:0];
    endfunction

    function automatic logic [NBITS-1:0] shape_result(input logic [NBITS-1:0] p);
`ifdef CONV_FEEDER_RELU_EN
        return p[NBITS-1] ? '0 : p;
`else
        return p;
`endif
    endfunction

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        row_d       = row_q;
        col_d       = col_q;
        taps_d      = taps_q;
        img_rd_d    = 1'b0;
        img_addr_d  = img_addr_q;
        mac_start_d = 1'b0;
        res_we_d    = 1'b0;
        res_addr_d  = res_addr_q;
        res_data_d  = res_data_q;
        finished_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d    = FETCH;
                    k_d        = 4'd0;
                    row_d      = '0;
                    col_d      = '0;
                    img_rd_d   = 1'b1;
                    img_addr_d = fetch_addr('0, '0, 4'd0);
                end
            end
            FETCH: begin
                // Read k-1 returns its data this cycle.
                if (k_q != 4'd0) taps_d[k_q - 4'd1] = img_data;
                if (k_q == 4'd8) begin
                    state_d = LAST;
                end else begin
                    k_d        = k_q + 4'd1;
                    img_rd_d   = 1'b1;
                    img_addr_d = fetch_addr(row_q, col_q, k_q + 4'd1);
                end
            end
            LAST: begin
                taps_d[8]   = img_data;
                state_d     = START;
                mac_start_d = 1'b1;
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mac_done) begin
                    res_data_d = shape_result(mac_P);
                    res_addr_d = res_index(row_q, col_q);
                    res_we_d   = 1'b1;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                if (int'(row_q) == IMG_H - 3 && int'(col_q) == IMG_W - 3) begin
                    state_d    = IDLE;
                    finished_d = 1'b1;
                end else begin
                    if (int'(col_q) == IMG_W - 3) begin
                        col_d = '0;
                        row_d = row_q + AW'(1);
                    end else begin
                        col_d = col_q + AW'(1);
                    end
                    state_d    = FETCH;
                    k_d        = 4'd0;
                    img_rd_d   = 1'b1;
                    img_addr_d = fetch_addr(row_d, col_d, 4'd0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any pass in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_q         <= 4'd0;
            row_q       <= '0;
            col_q       <= '0;
            taps_q      <= '0;
            img_rd_q    <= 1'b0;
            img_addr_q  <= '0;
            mac_start_q <= 1'b0;
            res_we_q    <= 1'b0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
            finished_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            row_q       <= row_d;
            col_q       <= col_d;
            taps_q      <= taps_d;
            img_rd_q    <= img_rd_d;
            img_addr_q  <= img_addr_d;
            mac_start_q <= mac_start_d;
            res_we_q    <= res_we_d;
            res_addr_q  <= res_addr_d;
            res_data_q  <= res_data_d;
            finished_q  <= finished_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign finished    = finished_q;
    assign img_rd      = img_rd_q;
    assign img_addr    = img_addr_q;
    assign mac_inputs9 = taps_q;
    assign mac_start   = mac_start_q;
    assign res_we      = res_we_q;
    assign res_addr    = res_addr_q;
    assign res_data    = res_data_q;

endmodule
